// File: rtl/conv_pkg.sv
// Shared definitions for the convolution front end.
//
// Contents:
//   seqState_e  - frame sequencer state encoding (IDLE, RUN, DRAIN, DONE)
//   K_DIM       - window side, fixed at 3
//   slotIndex() - flat window slot index k = r*K_DIM + c, r=0 is the oldest row
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } seqState_e;

  localparam int K_DIM = 3;

  function automatic int slotIndex(input int r, input int c);
    return r * K_DIM + c;
  endfunction

endpackage

// File: rtl/conv_window_sequencer.sv
// Frame-level controller for the 3x3 line-buffer window generator.
//
// Accepts a raster pixel stream (valid/ready), feeds the line buffer enable
// and data, stalls it under downstream backpressure, masks edge and
// wrap-around windows, tags legal windows with their top-left coordinates,
// and pushes IMG_W dummy pixels at frame end so the line buffer write
// pointer is realigned to 0 for the next frame.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               one-cycle pulse, begins a frame when idle
//   s_valid/s_ready     input pixel handshake, s_data signed pixel
//   lb_en/lb_data       line buffer enable and write data
//   lb_win              line buffer window (slot k = r*3+c, r=0 oldest row)
//   m_valid/m_ready     window handshake, m_win pass-through of lb_win
//   m_row/m_col         top-left coordinates of the emitted window
//   busy                high in every state except IDLE
//   frame_done          one-cycle pulse at end of frame
module conv_window_sequencer
  import conv_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int IMG_W  = 9,
  localparam int WIN_W  = K_DIM * K_DIM * DATA_W,
  localparam int CW     = $clog2(IMG_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              lb_en,
  output logic [DATA_W-1:0] lb_data,
  input  logic [WIN_W-1:0]  lb_win,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [WIN_W-1:0]  m_win,
  output logic [CW-1:0]     m_row,
  output logic [CW-1:0]     m_col,
  output logic              busy,
  output logic              frame_done
);

  localparam logic [CW-1:0] LAST_IDX = CW'(IMG_W - 1);
  localparam logic [CW-1:0] TWO      = CW'(2);
  localparam logic [CW-1:0] ONE      = CW'(1);

  seqState_e         state_q, state_d;
  logic [CW-1:0]     row_q, row_d;
  logic [CW-1:0]     col_q, col_d;
  logic [CW-1:0]     prevRow_q, prevRow_d;
  logic [CW-1:0]     prevCol_q, prevCol_d;
  logic              prevVld_q, prevVld_d;
  logic [CW-1:0]     drainCnt_q, drainCnt_d;
  logic              mValid_q, mValid_d;
  logic [CW-1:0]     mRow_q, mRow_d;
  logic [CW-1:0]     mCol_q, mCol_d;

  logic              enOk;
  logic              lbEn;
  logic [DATA_W-1:0] lbData;
  logic              sReady;
  logic              frameDone;

  // The line buffer window moves on every enable, so enables are only
  // allowed when the current window slot is empty or being consumed.
  assign enOk = !mValid_q || m_ready;

  // Next-state logic: sequencing, coordinate counters and the window tag.
  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    prevRow_d  = prevRow_q;
    prevCol_d  = prevCol_q;
    prevVld_d  = prevVld_q;
    drainCnt_d = drainCnt_q;
    mValid_d   = mValid_q;
    mRow_d     = mRow_q;
    mCol_d     = mCol_q;
    lbEn       = 1'b0;
    lbData     = '0;
    sReady     = 1'b0;
    frameDone  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = RUN;
          row_d      = '0;
          col_d      = '0;
          drainCnt_d = '0;
          prevVld_d  = 1'b0;
        end
      end
      RUN: begin
        sReady = enOk;
        lbEn   = s_valid && enOk;
        lbData = s_data;
        if (lbEn) begin
          prevRow_d = row_q;
          prevCol_d = col_q;
          prevVld_d = 1'b1;
          if (col_q == LAST_IDX) begin
            col_d = '0;
            if (row_q == LAST_IDX) begin
              row_d      = '0;
              drainCnt_d = '0;
              state_d    = DRAIN;
            end else begin
              row_d = row_q + ONE;
            end
          end else begin
            col_d = col_q + ONE;
          end
        end
      end
      DRAIN: begin
        // Zero pixels flush the last window out and bring the frame length
        // to a multiple of IMG_W, keeping the line buffer aligned.
        lbEn = enOk;
        if (lbEn) begin
          prevVld_d = 1'b0;
          if (drainCnt_q == LAST_IDX) begin
            drainCnt_d = '0;
            state_d    = DONE;
          end else begin
            drainCnt_d = drainCnt_q + ONE;
          end
        end
      end
      DONE: begin
        if (!mValid_q) begin
          frameDone = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // The window visible after this enable ends at the previously accepted
    // pixel, so the tag is built from the prev_* registers, not the counters.
    if (lbEn) begin
      mValid_d = prevVld_q && (prevRow_q >= TWO) && (prevCol_q >= TWO);
      mRow_d   = prevRow_q - TWO;
      mCol_d   = prevCol_q - TWO;
    end else begin
      mValid_d = mValid_q && !m_ready;
    end
  end

  // State and tag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      row_q      <= '0;
      col_q      <= '0;
      prevRow_q  <= '0;
      prevCol_q  <= '0;
      prevVld_q  <= 1'b0;
      drainCnt_q <= '0;
      mValid_q   <= 1'b0;
      mRow_q     <= '0;
      mCol_q     <= '0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      prevRow_q  <= prevRow_d;
      prevCol_q  <= prevCol_d;
      prevVld_q  <= prevVld_d;
      drainCnt_q <= drainCnt_d;
      mValid_q   <= mValid_d;
      mRow_q     <= mRow_d;
      mCol_q     <= mCol_d;
    end
  end

  assign s_ready    = sReady;
  assign lb_en      = lbEn;
  assign lb_data    = lbData;
  assign m_valid    = mValid_q;
  assign m_win      = lb_win;
  assign m_row      = mRow_q;
  assign m_col      = mCol_q;
  assign busy       = (state_q != IDLE);
  assign frame_done = frameDone;

endmodule

// File: tb/tb_conv_window_sequencer.sv
// Self-checking bench for conv_window_sequencer.
// A behavioural 3x3 line buffer sits beside the DUT; a table of frame
// scenarios is run in a loop, followed by a hand-written mid-frame reset.
module tb_conv_window_sequencer;
  import conv_pkg::*;

  localparam int DATA_W = 8;
  localparam int IMG_W  = 9;
  localparam int WIN_W  = 72;
  localparam int CW     = 4;
  localparam int OUT_W  = IMG_W - 2;
  localparam int WINS   = OUT_W * OUT_W;
  localparam int PIXELS = IMG_W * IMG_W;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_ready;
  logic              lb_en;
  logic [DATA_W-1:0] lb_data;
  logic [WIN_W-1:0]  lb_win;
  logic              m_valid;
  logic              m_ready;
  logic [WIN_W-1:0]  m_win;
  logic [CW-1:0]     m_row;
  logic [CW-1:0]     m_col;
  logic              busy;
  logic              frame_done;

  int compares   = 0;
  int mismatches = 0;

  always #5 clk = ~clk;

  conv_window_sequencer #(.DATA_W(DATA_W), .IMG_W(IMG_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .lb_en(lb_en), .lb_data(lb_data), .lb_win(lb_win),
    .m_valid(m_valid), .m_ready(m_ready), .m_win(m_win),
    .m_row(m_row), .m_col(m_col), .busy(busy), .frame_done(frame_done)
  );

  // Line buffer model: after an enable, the window ends at the pixel written
  // by the previous enable. Enable/data are latched by the bench before the
  // edge so the model never races the DUT registers.
  logic              enSample = 1'b0;
  logic [DATA_W-1:0] dataSample = '0;
  logic [DATA_W-1:0] stream[$];

  always @(posedge clk or negedge rst_n) begin : lbModel
    logic [WIN_W-1:0] w;
    int idx;
    if (!rst_n) begin
      stream.delete();
      lb_win <= '0;
    end else if (enSample) begin
      w = '0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++) begin
          idx = stream.size() - 1 - (2 - r) * IMG_W - (2 - c);
          if (idx >= 0) w[slotIndex(r, c)*8 +: 8] = stream[idx];
        end
      lb_win <= w;
      stream.push_back(dataSample);
    end
  end

  typedef struct {
    string            name;
    int               base;
    int               readyMode;
    bit               bubbles;
    bit               startBusy;
    int               tail;
    bit               checkLatency;
    logic [WIN_W-1:0] expFirst;
    logic [WIN_W-1:0] expLast;
  } frameVec_t;

  frameVec_t vecs[6];

  function automatic logic [WIN_W-1:0] mkWin(input int a0, input int a1, input int a2,
                                             input int a3, input int a4, input int a5,
                                             input int a6, input int a7, input int a8);
    logic [WIN_W-1:0] w;
    w = {8'(a8), 8'(a7), 8'(a6), 8'(a5), 8'(a4), 8'(a3), 8'(a2), 8'(a1), 8'(a0)};
    return w;
  endfunction

  // Expected n-th window of a ramp frame starting at value base.
  function automatic logic [WIN_W-1:0] modelWin(input int base, input int n);
    logic [WIN_W-1:0] w;
    int row;
    int col;
    row = n / OUT_W;
    col = n % OUT_W;
    w = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        w[slotIndex(r, c)*8 +: 8] = 8'(base + (row + r) * IMG_W + col + c);
    return w;
  endfunction

  task automatic checkOutput(input string name, input logic [95:0] actual,
                             input logic [95:0] expected);
    compares++;
    if (actual !== expected) begin
      mismatches++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic st, input logic sv, input logic [DATA_W-1:0] sd,
                               input logic mr);
    @(negedge clk);
    start   = st;
    s_valid = sv;
    s_data  = sd;
    m_ready = mr;
    #1;
    enSample   = lb_en;
    dataSample = lb_data;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, " m_valid"}, 96'(m_valid), 96'(0));
    checkOutput({tag, " m_row"}, 96'(m_row), 96'(0));
    checkOutput({tag, " m_col"}, 96'(m_col), 96'(0));
    checkOutput({tag, " frame_done"}, 96'(frame_done), 96'(0));
    checkOutput({tag, " busy"}, 96'(busy), 96'(0));
    checkOutput({tag, " s_ready"}, 96'(s_ready), 96'(0));
    checkOutput({tag, " lb_en"}, 96'(lb_en), 96'(0));
  endtask

  // Runs one frame from vecs[vi]; abortAt >= 0 stops once that many pixels
  // have been accepted, without end-of-frame checks.
  task automatic runFrame(input int vi, input int abortAt);
    int iter = 0;
    int pixIdx = 0;
    int winCount = 0;
    int dummies = 0;
    int lastPixIter = 0;
    int doneIter = 0;
    bit done = 0;
    bit aborted = 0;
    bit prevStall = 0;
    bit startRunSent = 0;
    bit startDrainSent = 0;
    logic [WIN_W-1:0] holdWin = '0;
    logic [CW-1:0] holdRow = '0;
    logic [CW-1:0] holdCol = '0;
    logic [WIN_W-1:0] firstWin = '0;
    logic [WIN_W-1:0] lastWin = '0;
    logic st, sv, mr;
    int base;
    base = vecs[vi].base;
    while (!done && iter < 3000) begin
      sv = 1'b1;
      if (vecs[vi].bubbles && $urandom_range(0, 3) == 0) sv = 1'b0;
      mr = (vecs[vi].readyMode == 0) ? 1'b1 : ((iter % 4 == 0) || (iter % 4 == 3));
      st = (iter == 0);
      if (vecs[vi].startBusy && !startRunSent && pixIdx == 20) begin
        st = 1'b1;
        startRunSent = 1;
      end
      if (vecs[vi].startBusy && !startDrainSent && pixIdx == PIXELS && dummies == 3) begin
        st = 1'b1;
        startDrainSent = 1;
      end
      applyStimulus(st, sv, 8'(base + pixIdx), mr);

      if (prevStall)
        checkOutput("hold", {15'd0, m_valid, m_row, m_col, m_win},
                    {15'd0, 1'b1, holdRow, holdCol, holdWin});
      if (m_valid && !m_ready)
        checkOutput("stall lb_en/s_ready", 96'({lb_en, s_ready}), 96'(0));
      prevStall = m_valid && !m_ready;
      holdWin = m_win;
      holdRow = m_row;
      holdCol = m_col;

      if (s_valid && (!busy || pixIdx == PIXELS))
        checkOutput("no accept outside RUN", 96'(s_ready), 96'(0));

      if (m_valid && m_ready) begin
        if (winCount < WINS)
          checkOutput($sformatf("window %0d", winCount), {16'd0, m_row, m_col, m_win},
                      {16'd0, CW'(winCount / OUT_W), CW'(winCount % OUT_W),
                       modelWin(base, winCount)});
        if (winCount == 0) firstWin = m_win;
        lastWin = m_win;
        winCount++;
      end

      if (pixIdx == PIXELS && lb_en) begin
        dummies++;
        checkOutput("dummy data", 96'(lb_data), 96'(0));
      end

      if (s_valid && s_ready) begin
        pixIdx++;
        if (pixIdx == PIXELS) lastPixIter = iter;
      end

      if (frame_done) begin
        doneIter = iter;
        done = 1;
      end
      if (abortAt >= 0 && pixIdx >= abortAt) begin
        done = 1;
        aborted = 1;
      end
      iter++;
    end

    if (aborted) return;
    if (!frame_done) begin
      checkOutput({vecs[vi].name, " frame_done timeout"}, 96'(0), 96'(1));
      return;
    end
    checkOutput({vecs[vi].name, " window count"}, 96'(winCount), 96'(WINS));
    checkOutput({vecs[vi].name, " first window"}, 96'(firstWin), 96'(vecs[vi].expFirst));
    checkOutput({vecs[vi].name, " last window"}, 96'(lastWin), 96'(vecs[vi].expLast));
    checkOutput({vecs[vi].name, " dummy count"}, 96'(dummies), 96'(IMG_W));
    if (vecs[vi].checkLatency)
      checkOutput({vecs[vi].name, " frame_done latency"}, 96'(doneIter - lastPixIter),
                  96'(IMG_W + 1));
    for (int t = 0; t < vecs[vi].tail; t++) begin
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
      checkOutput({vecs[vi].name, " idle after frame"}, 96'({busy, frame_done}), 96'(0));
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    s_valid = 1'b1;
    s_data  = '0;
    m_ready = 1'b1;

    vecs[0] = '{"ramp", 0, 0, 0, 0, 4, 1,
                mkWin(0, 1, 2, 9, 10, 11, 18, 19, 20),
                mkWin(60, 61, 62, 69, 70, 71, 78, 79, 80)};
    vecs[1] = '{"backpressure", 0, 1, 0, 0, 4, 0,
                mkWin(0, 1, 2, 9, 10, 11, 18, 19, 20),
                mkWin(60, 61, 62, 69, 70, 71, 78, 79, 80)};
    vecs[2] = '{"bubbles", 0, 0, 1, 0, 4, 0,
                mkWin(0, 1, 2, 9, 10, 11, 18, 19, 20),
                mkWin(60, 61, 62, 69, 70, 71, 78, 79, 80)};
    vecs[3] = '{"b2b frame1", 0, 0, 0, 0, 0, 1,
                mkWin(0, 1, 2, 9, 10, 11, 18, 19, 20),
                mkWin(60, 61, 62, 69, 70, 71, 78, 79, 80)};
    vecs[4] = '{"b2b frame2", 100, 0, 0, 0, 4, 1,
                mkWin(100, 101, 102, 109, 110, 111, 118, 119, 120),
                mkWin(160, 161, 162, 169, 170, 171, 178, 179, 180)};
    vecs[5] = '{"start while busy", 0, 0, 0, 1, 12, 1,
                mkWin(0, 1, 2, 9, 10, 11, 18, 19, 20),
                mkWin(60, 61, 62, 69, 70, 71, 78, 79, 80)};

    #23;
    checkResetOutputs("power-on reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      $display("[TB] scenario: %s", vecs[i].name);
      runFrame(i, -1);
    end

    // Mid-frame reset after pixel 40, then a clean ramp frame.
    $display("[TB] scenario: reset mid-frame");
    runFrame(0, 41);
    #3;
    rst_n    = 1'b0;
    enSample = 1'b0;
    start    = 1'b0;
    s_valid  = 1'b1;
    #1;
    checkResetOutputs("mid-frame reset");
    repeat (3) @(negedge clk);
    checkResetOutputs("held reset");
    rst_n = 1'b1;
    runFrame(0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, mismatches);
    $finish;
  end

endmodule

// File: doc/conv_window_sequencer.md
Name: conv_window_sequencer

Overview:
Frame-level controller for the 3x3 line-buffer window generator feeding the conv datapath. It accepts a pixel stream with a valid/ready handshake and drives the line buffer's enable and data inputs, stalling them under downstream backpressure. It masks edge and wrap-around windows, tags each legal window with its coordinates, and drains and realigns the line buffer at frame end so back-to-back frames need no reset.

Parameters:
DATA_W, 8, pixel width (signed)
IMG_W, 9, square image side in pixels; must be >= 3
K_DIM, 3, window side; fixed at 3 for this block
WIN_W, K_DIM*K_DIM*DATA_W, flat window width (derived, localparam)
CW, $clog2(IMG_W), coordinate counter width (derived, localparam)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low; shared with the line buffer
start  in  1  one-cycle pulse; begins a frame when idle
s_valid  in  1  input pixel valid
s_data  in  DATA_W  input pixel, signed, raster order
s_ready  out  1  pixel accepted when s_valid & s_ready
lb_en  out  1  line buffer i_en
lb_data  out  DATA_W  line buffer i_data
lb_win  in  WIN_W  line buffer o_win_flat; slot k = r*3+c, r=0 is the oldest row
m_valid  out  1  window valid
m_ready  in  1  downstream accepts window
m_win  out  WIN_W  window; combinational pass-through of lb_win
m_row  out  CW  output row = top-left pixel row of the window
m_col  out  CW  output column = top-left pixel column of the window
busy  out  1  high in every state except IDLE
frame_done  out  1  one-cycle pulse at end of frame

Behaviour:
- Reset values: m_valid=0, m_row=0, m_col=0, frame_done=0, busy=0, state=IDLE, all counters 0, prev_vld=0.
- en_ok = !m_valid | m_ready. lb_en must never assert when en_ok=0, because lb_win changes on every enable.
- States:
  - IDLE: on start go to RUN; row and column counters cleared.
  - RUN: s_ready = en_ok; lb_en = s_valid & en_ok; lb_data = s_data.
  - DRAIN: s_ready=0; lb_en = en_ok; lb_data = 0. Exactly IMG_W dummy enables are issued.
  - DONE: wait until m_valid=0, then pulse frame_done for one cycle and return to IDLE.
- Transitions: RUN to DRAIN on the enable carrying pixel (IMG_W-1, IMG_W-1). DRAIN to DONE on the IMG_W-th dummy enable.
- Window tagging, one enable of lag: the lb_win produced at enable k has its bottom-right pixel at the pixel of enable k-1.
  - The controller holds prev_row, prev_col and prev_vld for the previous accepted pixel.
  - On each enable: m_valid <= prev_vld & prev_row>=2 & prev_col>=2; m_row <= prev_row-2; m_col <= prev_col-2.
  - In RUN, prev_* then load the current pixel coordinates with prev_vld=1.
  - In DRAIN, the first dummy enable emits window (IMG_W-3, IMG_W-3) and clears prev_vld; later dummies emit nothing.
- With no enable, m_valid <= m_valid & !m_ready. m_row, m_col and m_win hold while m_valid & !m_ready.
- Latency: the window whose bottom-right is pixel p appears on the cycle after the enable of pixel p+1, or of the first dummy for the last pixel.
- The line buffer's o_valid is not used; its row count wraps across frames, so masking relies only on this block's counters.
- Alignment: a frame of IMG_W*IMG_W pixels plus IMG_W dummies is a multiple of IMG_W. The line-buffer write pointer is therefore 0 at every frame start.
- Windows emitted per frame: (IMG_W-2)^2. Rows from a stale previous frame never reach an emitted window, since masking requires row>=2.
- Boundary conditions:
  - start while busy is ignored.
  - s_valid in IDLE or DONE is not accepted (s_ready=0).
  - Simultaneous m_ready and enable: the new window replaces the old one in the same cycle (full throughput, 1 pixel/cycle).
  - Reset mid-frame: everything returns to reset values at once; the partial frame is discarded.

Decomposition:
- Shared package conv_pkg holds:
  - the state encoding (IDLE, RUN, DRAIN, DONE);
  - K_DIM=3;
  - the window slot index function k = r*K_DIM+c.
- No sub-module: the coordinate counters and the tag register live in this block.
- The line buffer is instantiated alongside it in the conv top level, not inside it.

Test Plan:
1. Ramp frame, no backpressure. Stimulus: IMG_W=9, start, s_data=0..80 with s_valid held high, m_ready=1. Required response:
   - exactly 49 windows;
   - first window m_row=0, m_col=0, slots {0,1,2,9,10,11,18,19,20};
   - last window (6,6), slots {60,61,62,69,70,71,78,79,80};
   - frame_done pulses once, 9 dummy cycles after pixel 80.
2. Backpressure. Stimulus: m_ready toggles 1,0,0,1 repeatedly. Required response:
   - lb_en=0 and s_ready=0 on every stalled cycle;
   - m_win, m_row and m_col hold;
   - the 49-window sequence is identical to scenario 1.
3. Bubbles. Stimulus: s_valid=0 on random cycles. Required response: no spurious windows; count=49; contents match scenario 1.
4. Back-to-back frames. Stimulus: a second start right after frame_done, ramp 100..180 (wrapped to signed 8-bit). Required response:
   - first window slots {100,101,102,109,110,111,118,119,120};
   - no window contains frame-1 data.
5. Reset mid-frame. Stimulus: assert rst_n low after pixel 40, then restart with the ramp. Required response:
   - all outputs 0 during reset;
   - the new frame matches scenario 1 exactly.
6. Start while busy. Stimulus: pulse start during RUN and again during DRAIN. Required response: ignored; exactly one frame_done.
